// File: rtl/lr_score_mac_pkg.sv
// Shared types for the logistic-regression score MAC: class count, score type,
// FSM states and the saturating add used when SCORE_SATURATE_EN is defined.
package lr_pkg;
  localparam int NUM_CLASS = 8;
  localparam int CLASS_W   = 3;
  localparam int SCORE_W   = 32;

  typedef logic signed [SCORE_W-1:0] score_t;

  // IDLE is only the post-reset holding state; the pipeline runs ACCUM/BIAS/DONE.
  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

  function automatic score_t sat_add(input score_t a, input score_t b);
    logic signed [SCORE_W:0] s;
    s = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
    if (s[SCORE_W] != s[SCORE_W-1])
      return s[SCORE_W] ? {1'b1, {(SCORE_W-1){1'b0}}} : {1'b0, {(SCORE_W-1){1'b1}}};
    return s[SCORE_W-1:0];
  endfunction
endpackage

// File: rtl/lr_mac_lane.sv
// One class accumulator: clear / add term. Wraps by default; clamps to the
// 32-bit signed range on every add when SCORE_SATURATE_EN is defined.
module lr_mac_lane
  import lr_pkg::*;
(
  input  logic   i_clock,
  input  logic   i_resetn,
  input  logic   i_clr,
  input  logic   i_add,
  input  score_t i_term,
  output score_t o_acc
);
  score_t r_acc;
  score_t w_sum;

  always_comb begin
`ifdef SCORE_SATURATE_EN
    w_sum = sat_add(r_acc, i_term);
`else
    w_sum = r_acc + i_term;
`endif
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetn)   r_acc <= '0;
    else if (i_clr)  r_acc <= '0;
    else if (i_add)  r_acc <= w_sum;
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/lr_score_mac.sv
// Eight-class logistic-regression score MAC: one feature per cycle, bias add,
// then a one-cycle h_valid pulse. Optional macro: SCORE_SATURATE_EN.
module lr_score_mac
  import lr_pkg::*;
#(
  parameter int NUM_FEAT = 16,
  parameter int FEAT_W   = 16,
  parameter int WGT_W    = 16,
  parameter int ACC_W    = 32
) (
  input  logic                        i_clock,
  input  logic                        i_resetn,
  input  logic                        i_wgt_we,
  input  logic                        i_bias_we,
  input  logic [CLASS_W-1:0]          i_wgt_class,
  input  logic [$clog2(NUM_FEAT)-1:0] i_wgt_idx,
  input  logic signed [WGT_W-1:0]     i_wgt_data,
  input  logic                        i_feat_valid,
  output logic                        o_feat_ready,
  input  logic signed [FEAT_W-1:0]    i_feat_data,
  output score_t                      o_harray [NUM_CLASS],
  output logic                        o_h_valid
);
  localparam int IDX_W  = $clog2(NUM_FEAT);
  localparam int PROD_W = FEAT_W + WGT_W;

  state_t r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic signed [WGT_W-1:0] r_wgt [NUM_CLASS][NUM_FEAT];
  logic signed [WGT_W-1:0] r_bias [NUM_CLASS];
  score_t r_harray [NUM_CLASS];
  logic   r_h_valid;

  logic   w_accept, w_last, w_wr_ok, w_clr, w_add;
  score_t w_term [NUM_CLASS];
  score_t w_acc  [NUM_CLASS];

  assign w_last  = (r_cnt == IDX_W'(NUM_FEAT - 1));
  assign w_wr_ok = (r_state == ACCUM) && (r_cnt == '0);

  always_comb begin
    w_state_nxt  = r_state;
    o_feat_ready = 1'b0;
    w_accept     = 1'b0;
    w_clr        = 1'b0;
    w_add        = 1'b0;
    case (r_state)
      IDLE:  w_state_nxt = ACCUM;
      ACCUM: begin
        o_feat_ready = 1'b1;
        w_accept     = i_feat_valid;
        w_add        = i_feat_valid;
        if (i_feat_valid && w_last) w_state_nxt = BIAS;
      end
      BIAS: begin
        w_add       = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_clr       = 1'b1;
        w_state_nxt = ACCUM;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_h_valid <= 1'b0;
      for (int c = 0; c < NUM_CLASS; c++) r_harray[c] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_h_valid <= (r_state == DONE);
      if (w_accept)             r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      else if (r_state == DONE) r_cnt <= '0;
      if (r_state == DONE)
        for (int c = 0; c < NUM_CLASS; c++) r_harray[c] <= w_acc[c];
    end
  end

  // Table writes land only between vectors; NBA ordering means a feature
  // accepted in the same cycle still multiplies by the old weight.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        r_bias[c] <= '0;
        for (int i = 0; i < NUM_FEAT; i++) r_wgt[c][i] <= '0;
      end
    end else if (w_wr_ok) begin
      if (i_bias_we)
        r_bias[i_wgt_class] <= i_wgt_data;
      else if (i_wgt_we && (32'(i_wgt_idx) < NUM_FEAT))
        r_wgt[i_wgt_class][i_wgt_idx] <= i_wgt_data;
    end
  end

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_lane
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext, w_bias_ext;

    assign w_prod     = i_feat_data * r_wgt[c][r_cnt];
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_bias_ext = ACC_W'(r_bias[c]);
    assign w_term[c]  = (r_state == BIAS) ? w_bias_ext : w_prod_ext;

    lr_mac_lane u_lane (
      .i_clock  (i_clock),
      .i_resetn (i_resetn),
      .i_clr    (w_clr),
      .i_add    (w_add),
      .i_term   (w_term[c]),
      .o_acc    (w_acc[c])
    );
  end

  assign o_harray  = r_harray;
  assign o_h_valid = r_h_valid;
endmodule

// File: tb/tb_lr_score_mac.sv
// Scoreboard bench for lr_score_mac: directed vectors push hand-computed scores,
// a negedge monitor pops and checks values and latency on every h_valid.
module tb_lr_score_mac;
  import lr_pkg::*;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              wgt_we = 1'b0, bias_we = 1'b0;
  logic [2:0]        wgt_class = '0;
  logic [3:0]        wgt_idx = '0;
  logic signed [15:0] wgt_data = '0;
  logic              feat_valid = 1'b0;
  logic              feat_ready;
  logic signed [15:0] feat_data = '0;
  score_t            harray [8];
  logic              h_valid;

  typedef struct {
    int    h [8];
    int    cyc;
    string name;
  } exp_t;

  exp_t sb [$];
  int   checks = 0, errors = 0;
  int   cyc = 0;

  lr_score_mac dut (
    .i_clock(clk), .i_resetn(resetn), .i_wgt_we(wgt_we), .i_bias_we(bias_we),
    .i_wgt_class(wgt_class), .i_wgt_idx(wgt_idx), .i_wgt_data(wgt_data),
    .i_feat_valid(feat_valid), .o_feat_ready(feat_ready), .i_feat_data(feat_data),
    .o_harray(harray), .o_h_valid(h_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every h_valid must match the oldest expectation, two edges after its last accept.
  always @(negedge clk) begin
    if (h_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_h_valid at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (cyc != e.cyc + 2) begin
          errors++;
          $display("FAIL %s latency: h_valid at edge %0d, required edge %0d", e.name, cyc, e.cyc + 2);
        end
        for (int c = 0; c < 8; c++) begin
          checks++;
          if (harray[c] !== e.h[c]) begin
            errors++;
            $display("FAIL %s lane%0d: got %0d, required %0d", e.name, c, harray[c], e.h[c]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic wr(input logic b, input logic w, input int c, input int idx, input int d);
    bias_we = b; wgt_we = w; wgt_class = 3'(c); wgt_idx = 4'(idx); wgt_data = 16'(d);
    @(posedge clk); #1;
    bias_we = 1'b0; wgt_we = 1'b0;
  endtask

  // Streams 16 features; optionally inserts bubbles and a class-3 weight write at feature wr_at.
  task automatic send_vec(input int f [16], input bit bub, input int wr_at, input int wr_idx,
                          input int wr_d, input exp_t e);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < 16 && guard < 200) begin
      guard++;
      feat_valid = !(bub && ($urandom_range(0, 2) == 0));
      feat_data  = 16'(f[i]);
      if (i == wr_at && feat_valid) begin
        wgt_we = 1'b1; wgt_class = 3'd3; wgt_idx = 4'(wr_idx); wgt_data = 16'(wr_d);
      end else wgt_we = 1'b0;
      @(negedge clk);
      acc = feat_valid && feat_ready;
      if (acc && i == 15) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (acc) i++;
    end
    wgt_we = 1'b0;
    chk({e.name, "_accept_budget"}, i, 16);
    // Offered features during BIAS/DONE must be refused.
    feat_valid = 1'b1; feat_data = 16'sh7fff;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk({e.name, "_ready_low"}, int'(feat_ready), 0);
      @(posedge clk); #1;
    end
    feat_valid = 1'b0;
    @(negedge clk);
    chk({e.name, "_ready_back"}, int'(feat_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string name);
    @(negedge clk);
    chk({name, "_ready"}, int'(feat_ready), 0);
    chk({name, "_hvalid"}, int'(h_valid), 0);
    for (int c = 0; c < 8; c++) chk({name, "_harray"}, harray[c], 0);
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int   fv [16];
    exp_t e;
    int   bias [8] = '{7, -1, 0, 100, 2000, -32768, 32767, 5};

    repeat (3) @(posedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Basic: w[c][i]=c+1, all-ones features.
    for (int c = 0; c < 8; c++) for (int i = 0; i < 16; i++) wr(0, 1, c, i, c + 1);
    for (int i = 0; i < 16; i++) fv[i] = 1;
    e.name = "basic";
    for (int c = 0; c < 8; c++) e.h[c] = 16 * (c + 1);
    send_vec(fv, 0, -1, 0, 0, e);

    // Signs and bias; biases written with both strobes high (bias must win).
    for (int c = 0; c < 8; c++) for (int i = 0; i < 16; i++) wr(0, 1, c, i, (c == 3) ? -2 : 0);
    for (int c = 0; c < 8; c++) wr(1, 1, c, 0, bias[c]);
    for (int i = 0; i < 16; i++) fv[i] = 5;
    e.name = "signs";
    for (int c = 0; c < 8; c++) e.h[c] = bias[c];
    e.h[3] = -60;
    send_vec(fv, 0, -1, 0, 0, e);

    // Bubbles with features -8..7: lane3 = -2*(-8) + 100.
    for (int i = 0; i < 16; i++) fv[i] = i - 8;
    e.name = "bubbles";
    e.h[3] = 116;
    send_vec(fv, 1, -1, 0, 0, e);
    for (int i = 0; i < 16; i++) fv[i] = 5;
    e.name = "bubbles5";
    e.h[3] = -60;
    send_vec(fv, 1, -1, 0, 0, e);

    // Write lockout at cnt=5, then same-cycle write at cnt=0 uses the old weight.
    e.name = "lockout";
    send_vec(fv, 0, 5, 7, 1000, e);
    e.name = "wr_cnt0";
    send_vec(fv, 0, 0, 0, 1000, e);
    e.name = "wr_next";
    e.h[3] = 4950;
    send_vec(fv, 0, -1, 0, 0, e);

    // Reset after 9 accepts: no result, everything cleared.
    feat_valid = 1'b1; feat_data = 16'sd3;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    resetn = 1'b0; feat_valid = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("midreset");
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk); #1;
    for (int c = 0; c < 8; c++) for (int i = 0; i < 16; i++) wr(0, 1, c, i, c + 1);
    for (int i = 0; i < 16; i++) fv[i] = i + 1;
    e.name = "post_reset";
    for (int c = 0; c < 8; c++) e.h[c] = 136 * (c + 1);
    send_vec(fv, 1, -1, 0, 0, e);

    // Overflow: 16 * 32767*32767 and 16 * (-32768*32767).
    for (int i = 0; i < 16; i++) begin
      wr(0, 1, 0, i, 32767);
      wr(0, 1, 1, i, -32768);
      fv[i] = 32767;
    end
    e.name = "overflow";
    for (int c = 2; c < 8; c++) e.h[c] = (c + 1) * 524272;
`ifdef SCORE_SATURATE_EN
    e.h[0] = 2147483647;
    e.h[1] = -2147483647 - 1;
`else
    e.h[0] = -1048560;
    e.h[1] = 524288;
`endif
    send_vec(fv, 0, -1, 0, 0, e);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
